// File: rtl/watch_pkg.sv
// Shared constants for the watch/timer display blocks: active-low segment
// patterns {g,f,e,d,c,b,a}, digit slot indices and a counter-width helper.
package watch_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam int DIG_ONESEC = 0;
    localparam int DIG_TENSEC = 1;
    localparam int DIG_ONEMIN = 2;
    localparam int DIG_TENMIN = 3;

    // Width of a counter that must hold 0..value-1; never narrower than one bit.
    function automatic int clog2w(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the timer cores (master) and the multiplexed display driver
// (slave): BCD digits and display controls in, board pin levels out.
interface seg7_scan_driver_if;

    logic [3:0] tenmin_in;
    logic [3:0] onemin_in;
    logic [3:0] tensec_in;
    logic [3:0] onesec_in;
    logic [3:0] blink_mask;
    logic       blank_lead_zero;
    logic       colon_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output tenmin_in, onemin_in, tensec_in, onesec_in,
        output blink_mask, blank_lead_zero, colon_en,
        input  an, seg, dp
    );

    modport slave (
        input  tenmin_in, onemin_in, tensec_in, onesec_in,
        input  blink_mask, blank_lead_zero, colon_en,
        output an, seg, dp
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a
// dash so bad upstream values are visible on the display.
module seg7_decode
    import watch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit driver with per-slot dead time,
// frame-coherent shadow digits, blinking, leading-zero blanking and colon.
module seg7_scan_driver
    import watch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 4,
    parameter int BLINK_DIV   = 50000000
)
(
    input logic              clk100MHz,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int RW = clog2w(REFRESH_DIV);
    localparam int BW = clog2w(BLINK_DIV);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] DEAD_LIMIT   = RW'(DEAD_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
    localparam logic [1:0]    IDX_ONEMIN   = 2'(DIG_ONEMIN);
    localparam logic [1:0]    IDX_TENMIN   = 2'(DIG_TENMIN);

    logic [RW-1:0]   refresh_cnt;
    logic [1:0]      idx;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic [3:0]      blink_mask_q;
    logic [3:0][3:0] shadow;

    logic            slot_end;
    logic            blink_end;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_seg;
    logic            suppress;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;
    logic            dp_d;

    assign slot_end  = (refresh_cnt == REFRESH_LAST);
    assign blink_end = (blink_cnt == BLINK_LAST);

    // Shadow digits reload only as slot 3 ends, so every frame shows one time value.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            refresh_cnt  <= '0;
            idx          <= 2'd0;
            blink_mask_q <= 4'b0000;
            shadow       <= '0;
        end else begin
            refresh_cnt <= slot_end ? '0 : refresh_cnt + 1'b1;
            if (slot_end) begin
                idx          <= idx + 2'd1;
                blink_mask_q <= bus.blink_mask;
                if (idx == IDX_TENMIN) begin
                    shadow <= {bus.tenmin_in, bus.onemin_in, bus.tensec_in, bus.onesec_in};
                end
            end
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            blink_cnt <= blink_end ? '0 : blink_cnt + 1'b1;
            if (blink_end) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    assign cur_digit = shadow[idx];

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    assign suppress = (blink_mask_q[idx] && !blink_phase) ||
                      (idx == IDX_TENMIN && bus.blank_lead_zero && shadow[IDX_TENMIN] == 4'd0);

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (refresh_cnt >= DEAD_LIMIT) begin
            an_d  = suppress ? 4'b1111 : ~(4'b0001 << idx);
            seg_d = cur_seg;
            dp_d  = !(idx == IDX_ONEMIN && bus.colon_en);
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            bus.an  <= 4'b1111;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_d;
            bus.seg <= seg_d;
            bus.dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with short refresh/blink periods; a
// table of digit/control vectors plus hand sequences for frame-edge cases.
module tb_seg7_scan_driver;

    localparam int REFRESH_DIV = 8;
    localparam int DEAD        = 2;
    localparam int BLINK       = 64;
    localparam int FRAME       = 4 * REFRESH_DIV;

    localparam logic [6:0] PBL = 7'b1111111;
    localparam logic [6:0] PDA = 7'b0111111;
    localparam logic [6:0] P0  = 7'b1000000;
    localparam logic [6:0] P1  = 7'b1111001;
    localparam logic [6:0] P2  = 7'b0100100;
    localparam logic [6:0] P3  = 7'b0110000;
    localparam logic [6:0] P4  = 7'b0011001;
    localparam logic [6:0] P5  = 7'b0010010;
    localparam logic [6:0] P6  = 7'b0000010;
    localparam logic [6:0] P7  = 7'b1111000;
    localparam logic [6:0] P8  = 7'b0000000;
    localparam logic [6:0] P9  = 7'b0010000;

    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef struct {
        logic [3:0]      tenmin;
        logic [3:0]      onemin;
        logic [3:0]      tensec;
        logic [3:0]      onesec;
        logic [3:0]      mask;
        logic            blank;
        logic            colon;
        logic [3:0][3:0] exp_an;
        logic [3:0][6:0] exp_seg;
        logic [3:0]      exp_dp;
    } vec_t;

    logic clk100MHz = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   g_obs = -1;
    vec_t vecs [5];
    vec_t zero_v, old_v, new_v, lit_v, dark_v;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD),
        .BLINK_DIV   (BLINK)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic tick();
        @(negedge clk100MHz);
        g_obs++;
    endtask

    task automatic goto_g(input int target);
        while (g_obs < target) tick();
    endtask

    task automatic applyStimulus(input logic [3:0] tm, input logic [3:0] om, input logic [3:0] ts,
                                 input logic [3:0] os, input logic [3:0] mask,
                                 input logic blank, input logic colon);
        bus.tenmin_in       = tm;
        bus.onemin_in       = om;
        bus.tensec_in       = ts;
        bus.onesec_in       = os;
        bus.blink_mask      = mask;
        bus.blank_lead_zero = blank;
        bus.colon_en        = colon;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_an,
                               input logic [6:0] exp_seg, input logic exp_dp);
        checks++;
        if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
            failures++;
            $display("[TB] FAIL %s g=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, g_obs, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    task automatic applyVec(input vec_t v);
        applyStimulus(v.tenmin, v.onemin, v.tensec, v.onesec, v.mask, v.blank, v.colon);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk100MHz);
        checkOutput("in_reset", 4'b1111, PBL, 1'b1);
        rst = 1'b0;
        g_obs = -1;
    endtask

    // Every position of the chosen slots: blank during dead time, vector pattern after.
    task automatic check_frame(input string name, input int frame, input vec_t v,
                               input int first_slot, input int last_slot);
        for (int s = first_slot; s <= last_slot; s++) begin
            for (int p = 0; p < REFRESH_DIV; p++) begin
                goto_g(frame * FRAME + s * REFRESH_DIV + p);
                if (p < DEAD)
                    checkOutput($sformatf("%s_f%0d_s%0d_dead", name, frame, s), 4'b1111, PBL, 1'b1);
                else
                    checkOutput($sformatf("%s_f%0d_s%0d_p%0d", name, frame, s, p),
                                v.exp_an[s], v.exp_seg[s], v.exp_dp[s]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P1, P2, P3, P4}, 4'b1111};
        vecs[1] = '{4'd0, 4'd5, 4'd5, 4'd9, 4'b0000, 1'b1, 1'b1,
                    {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {P0, P5, P5, P9}, 4'b1011};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P0, P0, P0, P0}, 4'b1111};
        vecs[3] = '{4'd5, 4'd8, 4'd7, 4'hC, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P5, P8, P7, PDA}, 4'b1111};
        vecs[4] = '{4'd6, 4'hF, 4'hA, 4'd0, 4'b0000, 1'b1, 1'b1,
                    AN_ALL, {P6, PDA, PDA, P0}, 4'b1011};
        zero_v  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P0, P0, P0, P0}, 4'b1111};
        old_v   = '{4'd0, 4'd5, 4'd5, 4'd9, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P0, P5, P5, P9}, 4'b1111};
        new_v   = '{4'd1, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0,
                    AN_ALL, {P1, P0, P0, P0}, 4'b1111};
        lit_v   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b0011, 1'b0, 1'b1,
                    AN_ALL, {P1, P2, P3, P4}, 4'b1011};
        dark_v  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b0011, 1'b0, 1'b1,
                    {4'b0111, 4'b1011, 4'b1111, 4'b1111}, {P1, P2, P3, P4}, 4'b1011};

        // Table: first frame shows reset shadow, second frame the latched inputs.
        for (int i = 0; i < 5; i++) begin
            applyVec(vecs[i]);
            do_reset();
            if (i == 0) check_frame("first_frame", 0, zero_v, 0, 3);
            check_frame($sformatf("vec%0d", i), 1, vecs[i], 0, 3);
        end

        // Inputs change mid-frame: current frame completes, next frame is coherent.
        applyVec(old_v);
        do_reset();
        check_frame("tear_old", 1, old_v, 0, 0);
        goto_g(FRAME + REFRESH_DIV);
        applyVec(new_v);
        check_frame("tear_old", 1, old_v, 1, 3);
        check_frame("tear_new", 2, new_v, 0, 3);

        // Blinking digits 0-1: lit in phase 1 frames, dark in phase 0 frames.
        applyVec(lit_v);
        do_reset();
        check_frame("blink_lit", 1, lit_v, 0, 3);
        check_frame("blink_dark", 2, dark_v, 0, 3);
        check_frame("blink_relit", 4, lit_v, 0, 1);

        // Reset during active part of slot 2 restarts scanning with full dead time.
        goto_g(5 * FRAME + 2 * REFRESH_DIV + 4);
        checkOutput("pre_rst_slot2", 4'b1011, P2, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst", 4'b1111, PBL, 1'b1);
        rst = 1'b0;
        g_obs = -1;
        goto_g(0);
        checkOutput("post_rst_dead0", 4'b1111, PBL, 1'b1);
        goto_g(1);
        checkOutput("post_rst_dead1", 4'b1111, PBL, 1'b1);
        goto_g(2);
        checkOutput("post_rst_slot0", 4'b1110, P0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
